// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared declarations for the parametrised UART receiver slice:
//   - uart_state_e : receiver FSM state encoding
//   - DEF_*        : default configuration constants
//   - DEF_PTR_W / DEF_CNT_W : FIFO pointer / occupancy widths for the defaults
//   - parity_of()  : XOR of a data word (zero-extended to 9 bits) and a parity bit
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_STOP_BITS  = 2;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DIV_W      = 10;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int MAX_DATA_BITS  = 9;

  localparam int DEF_PTR_W = $clog2(DEF_FIFO_DEPTH);
  localparam int DEF_CNT_W = DEF_PTR_W + 1;

  // Returns 0 when data plus parity bit hold an even number of ones.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic                     par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock circular-buffer FIFO with a registered read port.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : write request and word (ignored when full unless a pop
//                    happens in the same cycle)
//   pop            : read request (ignored when empty)
//   read_data      : word popped on the last accepted pop (1-cycle latency)
//   empty, full    : registered occupancy flags
//   count          : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [WIDTH-1:0] read_data_r;
  logic             empty_r;
  logic             full_r;
  logic             do_pop_s;
  logic             do_push_s;

  // Accept decisions and next occupancy; a pop frees the slot for a push when full.
  always_comb begin
    do_pop_s    = pop & ~empty_r;
    do_push_s   = push & (~full_r | do_pop_s);
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + 1'b1;
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - 1'b1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy, flags and registered read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      read_data_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r    <= rd_ptr_r + 1'b1;
        read_data_r <= mem_r[rd_ptr_r];
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == '0);
      full_r  <= (count_nxt_s == FULL_CNT);
    end
  end

  assign read_data = read_data_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign count     = count_r;

endmodule

// File: rtl/uart_rx_fifo_param.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_param
// Parametrised UART receiver (start + DATA_BITS LSB-first + STOP_BITS stop)
// with an oversampling tick generator and an integrated receive FIFO.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits, with parity_odd / parity_err ports.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rx          : asynchronous serial input, idle high
//   baud_div    : tick period minus 1 in clk cycles (latched at each wrap)
//   read_en     : pop request
//   read_data   : popped word, valid the cycle after the pop
//   empty, full : FIFO status
//   frame_err   : 1-cycle pulse, a stop sample was low (word discarded)
//   overrun     : 1-cycle pulse, good word dropped because FIFO was full
//   parity_odd  : (UART_RX_PARITY_EN) 1 = odd parity, 0 = even
//   parity_err  : (UART_RX_PARITY_EN) 1-cycle pulse, parity mismatch
// ---------------------------------------------------------------------------
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 read_en,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] read_data,
  output logic                 empty,
  output logic                 full,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [OS_W-1:0]  OS_HALF_M1    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_FULL_M1    = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST     = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Synchroniser
  logic rx_meta_r;
  logic rxs_r;

  // Tick generator
  logic [DIV_W-1:0] tick_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_s;

  // Receiver FSM
  uart_state_e      state_r;
  logic [OS_W-1:0]  os_cnt_r;
  logic [BIT_W-1:0] bit_idx_r;
  logic             stop_idx_r;
  logic             stop_bad_r;
  logic             brk_wait_r;
  logic             armed_r;
  logic [DATA_BITS-1:0] shift_r;
  logic             push_r;
  logic             frame_err_r;
  logic             overrun_r;
  logic             stop_err_s;
  logic             par_bad_s;
`ifdef UART_RX_PARITY_EN
  logic                     par_bit_r;
  logic                     par_err_r;
  logic [MAX_DATA_BITS-1:0] par_data_s;
`endif

  // FIFO interface
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             pop_ok_s;
  logic             drop_s;

  // Two-flop synchroniser for the asynchronous rx pin; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Tick strobe: the period register is reloaded only at a wrap, so a new
  // baud_div never truncates or stretches the tick in progress.
  always_comb begin
    tick_s = (tick_cnt_r == div_r);
  end

  // Oversampling tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= '0;
      div_r      <= baud_div;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      div_r      <= baud_div;
    end else begin
      tick_cnt_r <= tick_cnt_r + 1'b1;
    end
  end

  // Frame-end error decode and overrun detection.
  always_comb begin
    stop_err_s = stop_bad_r | ~rxs_r;
`ifdef UART_RX_PARITY_EN
    par_data_s                  = '0;
    par_data_s[DATA_BITS-1:0]   = shift_r;
    par_bad_s                   = parity_of(par_data_s, par_bit_r) ^ parity_odd;
`else
    par_bad_s = 1'b0;
`endif
    pop_ok_s = read_en & ~fifo_empty_s;
    drop_s   = push_r & (fifo_count_s == FIFO_FULL_CNT) & ~pop_ok_s;
  end

  // Receiver FSM with registered push / error strobes.
  // armed_r blocks start detection until the line has been seen idle after
  // reset; brk_wait_r holds the FSM in STOP after a framing error until the
  // line returns high, so a held break reports only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      os_cnt_r    <= '0;
      bit_idx_r   <= '0;
      stop_idx_r  <= 1'b0;
      stop_bad_r  <= 1'b0;
      brk_wait_r  <= 1'b0;
      armed_r     <= 1'b0;
      shift_r     <= '0;
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r   <= 1'b0;
      par_err_r   <= 1'b0;
`endif
    end else begin
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r   <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (!armed_r) begin
            armed_r <= rxs_r;
          end else if (!rxs_r) begin
            state_r  <= ST_START;
            os_cnt_r <= '0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (os_cnt_r == OS_HALF_M1) begin
              os_cnt_r <= '0;
              if (!rxs_r) begin
                state_r   <= ST_DATA;
                bit_idx_r <= '0;
              end else begin
                state_r   <= ST_IDLE;
              end
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (os_cnt_r == OS_FULL_M1) begin
              os_cnt_r <= '0;
              shift_r  <= {rxs_r, shift_r[DATA_BITS-1:1]};
              if (bit_idx_r == BIT_LAST) begin
                bit_idx_r  <= '0;
                stop_idx_r <= 1'b0;
                stop_bad_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
                state_r    <= ST_PARITY;
`else
                state_r    <= ST_STOP;
`endif
              end else begin
                bit_idx_r <= bit_idx_r + 1'b1;
              end
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
        end
        ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick_s) begin
            if (os_cnt_r == OS_FULL_M1) begin
              os_cnt_r  <= '0;
              par_bit_r <= rxs_r;
              state_r   <= ST_STOP;
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (brk_wait_r) begin
            if (rxs_r) begin
              brk_wait_r <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end else if (tick_s) begin
            if (os_cnt_r == OS_FULL_M1) begin
              os_cnt_r <= '0;
              if (stop_idx_r == STOP_LAST) begin
                frame_err_r <= stop_err_s;
`ifdef UART_RX_PARITY_EN
                par_err_r   <= par_bad_s;
`endif
                push_r      <= ~stop_err_s & ~par_bad_s;
                if (stop_err_s) begin
                  brk_wait_r <= 1'b1;
                end else begin
                  state_r    <= ST_IDLE;
                end
              end else begin
                stop_idx_r <= 1'b1;
                stop_bad_r <= stop_bad_r | ~rxs_r;
              end
            end else begin
              os_cnt_r <= os_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Overrun strobe, one cycle after the dropped push.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= drop_s;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (shift_r),
    .pop       (read_en),
    .read_data (read_data),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s)
  );

  assign empty     = fifo_empty_s;
  assign full      = fifo_full_s;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = par_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
module tb_uart_rx_fifo_param;

  localparam int DB = 8;
  localparam int SB = 2;
  localparam int OS = 16;
  localparam int DW = 10;
  localparam int FD = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DW-1:0] baud_div;
  logic          read_en;
  logic [DB-1:0] read_data;
  logic          empty;
  logic          full;
  logic          frame_err;
  logic          overrun;
  logic          par_odd_v;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int tests = 0;
  int fails = 0;
  int bit_cyc;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  int both_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] stop_v;
    logic       exp_ferr;
    logic       exp_store;
  } vec_t;

  always #10 clk = ~clk;

  uart_rx_fifo_param #(
    .DATA_BITS(DB), .STOP_BITS(SB), .OVERSAMPLE(OS), .DIV_W(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div), .read_en(read_en),
`ifdef UART_RX_PARITY_EN
    .parity_odd(par_odd_v), .parity_err(parity_err),
`endif
    .read_data(read_data), .empty(empty), .full(full),
    .frame_err(frame_err), .overrun(overrun)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
    if (parity_err === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
`endif
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_baud(input logic [DW-1:0] d);
    baud_div = d;
    bit_cyc  = OS * (int'(d) + 1);
    cyc(int'(d) + 400);
  endtask

  // One frame: start, data LSB first, optional parity, stop bits, short idle.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic [1:0] stop_v);
    logic [7:0] dv;
    dv = d;
    rx = 1'b0;
    cyc(bit_cyc);
    for (int i = 0; i < DB; i++) begin
      rx = dv[i];
      cyc(bit_cyc);
    end
    if (PAR_EN) begin
      rx = (^dv) ^ par_odd_v ^ bad_par;
      cyc(bit_cyc);
    end
    for (int i = 0; i < SB; i++) begin
      rx = stop_v[i];
      cyc(bit_cyc);
    end
    rx = 1'b1;
    cyc(6);
  endtask

  task automatic pop(output logic [7:0] d);
    read_en = 1'b1;
    cyc(1);
    read_en = 1'b0;
    d = read_data;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] last_rd;
    int f0, o0, p0, b0, k;
    vec_t vecs [7];

    vecs[0] = '{8'hA5, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 2'b11, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 2'b11, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 2'b11, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 2'b10, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 2'b11, 1'b0, 1'b1};
    vecs[6] = '{8'hC3, 2'b11, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; rx = 1'b1; read_en = 1'b0; par_odd_v = 1'b0;
    baud_div = 10'd325; bit_cyc = OS * 326;
    cyc(3);
    check("rst_read_data", read_data, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    cyc(10);

    // Glitch of 3 us (150 cycles) at baud_div=325: rejected silently
    f0 = ferr_cnt;
    rx = 1'b0; cyc(150); rx = 1'b1;
    cyc(3000);
    check("glitch_empty", empty, 1'b1);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Frame 0x0F at baud_div=325
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h0F, 1'b0, 2'b11);
    check("t1_not_empty", empty, 1'b0);
    pop(d);
    check("t1_read_data", d, 8'h0F);
    check("t1_empty_after", empty, 1'b1);
    check("t1_no_err", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    last_rd = 8'h0F;

    // Table of single frames at baud_div=3; every vector is followed by a pop
    set_baud(10'd3);
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].data, 1'b0, vecs[i].stop_v);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_empty", i), empty, !vecs[i].exp_store);
      if (vecs[i].exp_store) last_rd = vecs[i].data;
      pop(d);
      check($sformatf("vec%0d_read", i), d, last_rd);
      check($sformatf("vec%0d_empty_after", i), empty, 1'b1);
    end

    // Held break: exactly one frame_err, nothing stored, then recovery
    f0 = ferr_cnt;
    rx = 1'b0; cyc(bit_cyc * 25); rx = 1'b1; cyc(bit_cyc * 2);
    check("break_ferr_once", ferr_cnt - f0, 1);
    check("break_empty", empty, 1'b1);
    send_frame(8'h5A, 1'b0, 2'b11);
    pop(d);
    check("break_recover_read", d, 8'h5A);

    // Overrun with FIFO_DEPTH=4, tick every cycle
    set_baud(10'd0);
    o0 = ovr_cnt;
    for (int v = 1; v <= 4; v++) begin
      send_frame(8'(v), 1'b0, 2'b11);
      check($sformatf("t4_full_after_%0d", v), full, (v == 4));
    end
    check("t4_no_ovr_yet", ovr_cnt - o0, 0);
    send_frame(8'h05, 1'b0, 2'b11);
    check("t4_ovr_once", ovr_cnt - o0, 1);
    check("t4_full_kept", full, 1'b1);
    for (int v = 1; v <= 4; v++) begin
      pop(d);
      check($sformatf("t4_pop_%0d", v), d, 32'(v));
    end
    check("t4_empty_end", empty, 1'b1);

    // Pop in the same cycle as the push into a full FIFO.
    // The push edge is located by watching full rise on the fourth frame.
    for (int v = 1; v <= 3; v++) send_frame(8'(v), 1'b0, 2'b11);
    k = 0;
    fork
      send_frame(8'h04, 1'b0, 2'b11);
      begin
        while (full !== 1'b1 && k < 2000) begin
          cyc(1);
          k++;
        end
      end
    join
    check("t5_full_rise_seen", (k < 2000), 1'b1);
    o0 = ovr_cnt;
    fork
      send_frame(8'h05, 1'b0, 2'b11);
      begin
        cyc(k - 1);
        read_en = 1'b1;
        cyc(1);
        read_en = 1'b0;
        d = read_data;
      end
    join
    check("t5_first_pop", d, 8'h01);
    check("t5_no_overrun", ovr_cnt - o0, 0);
    check("t5_full_kept", full, 1'b1);
    for (int v = 2; v <= 5; v++) begin
      pop(d);
      check($sformatf("t5_pop_%0d", v), d, 32'(v));
    end
    check("t5_empty_end", empty, 1'b1);

`ifdef UART_RX_PARITY_EN
    // Parity: even with bad bit, even good, odd good, parity+stop error together
    p0 = perr_cnt; f0 = ferr_cnt;
    par_odd_v = 1'b0;
    send_frame(8'h0F, 1'b1, 2'b11);
    check("par_even_bad_perr", perr_cnt - p0, 1);
    check("par_even_bad_ferr", ferr_cnt - f0, 0);
    check("par_even_bad_empty", empty, 1'b1);
    send_frame(8'h0F, 1'b0, 2'b11);
    pop(d);
    check("par_even_good_read", d, 8'h0F);
    par_odd_v = 1'b1;
    send_frame(8'h0F, 1'b0, 2'b11);
    pop(d);
    check("par_odd_good_read", d, 8'h0F);
    p0 = perr_cnt; b0 = both_cnt;
    send_frame(8'h0F, 1'b1, 2'b01);
    cyc(10);
    check("par_both_same_cycle", both_cnt - b0, 1);
    check("par_both_perr", perr_cnt - p0, 1);
    check("par_both_empty", empty, 1'b1);
`else
    p0 = perr_cnt; b0 = both_cnt;
    check("no_parity_pulses", (perr_cnt - p0) + (both_cnt - b0), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
